// File: rtl/timebase_gen.sv
// timebase_gen: free-running 1 ms / 100 ms / 250 ms / 1 s strobe generator.
// Optional Wishbone slave (macro TIMEBASE_WB_EN) exposes CTRL/MS/SEC.
//
// Ports:
//   wb_clk_i            system clock
//   wb_rst_i            async active-high reset
//   wb_adr_i[3:0]       byte address, [3:2] decoded      (TIMEBASE_WB_EN)
//   wb_dat_i[31:0]      write data                       (TIMEBASE_WB_EN)
//   wb_dat_o[31:0]      registered read data             (TIMEBASE_WB_EN)
//   wb_we_i/cyc_i/stb_i Wishbone classic controls        (TIMEBASE_WB_EN)
//   wb_ack_o            single-cycle acknowledge         (TIMEBASE_WB_EN)
//   ms_edge             1-cycle pulse every 1 ms
//   tenth_second_edge   1-cycle pulse every 100 ms
//   quarter_second_edge 1-cycle pulse every 250 ms
//   second_edge         1-cycle pulse every 1000 ms
module timebase_gen #(
    parameter int CLKS_PER_MS = 100000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
`ifdef TIMEBASE_WB_EN
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
`endif
    output logic        ms_edge,
    output logic        tenth_second_edge,
    output logic        quarter_second_edge,
    output logic        second_edge
);

    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_MS - 1);

    logic [PW-1:0] presc;
    logic [9:0]    ms_cnt;
    // Side counters track ms_cnt mod 100 and mod 250 so the strobe
    // decode is a simple compare instead of a divider.
    logic [6:0]    tenth_cnt;
    logic [7:0]    quarter_cnt;

    logic enable;
    logic clear;

    logic tick;
    logic ms_wrap;
    logic tenth_wrap;
    logic quarter_wrap;
    logic count_ms;

    assign tick         = (presc == PRESC_MAX);
    assign ms_wrap      = (ms_cnt == 10'd999);
    assign tenth_wrap   = (tenth_cnt == 7'd99);
    assign quarter_wrap = (quarter_cnt == 8'd249);
    // A pending clear beats a same-cycle terminal count.
    assign count_ms     = enable & ~clear & tick;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            presc               <= '0;
            ms_cnt              <= '0;
            tenth_cnt           <= '0;
            quarter_cnt         <= '0;
            ms_edge             <= 1'b0;
            tenth_second_edge   <= 1'b0;
            quarter_second_edge <= 1'b0;
            second_edge         <= 1'b0;
        end else begin
            ms_edge             <= 1'b0;
            tenth_second_edge   <= 1'b0;
            quarter_second_edge <= 1'b0;
            second_edge         <= 1'b0;
            if (clear) begin
                presc       <= '0;
                ms_cnt      <= '0;
                tenth_cnt   <= '0;
                quarter_cnt <= '0;
            end else if (count_ms) begin
                presc               <= '0;
                ms_cnt              <= ms_wrap ? 10'd0 : ms_cnt + 10'd1;
                tenth_cnt           <= tenth_wrap ? 7'd0 : tenth_cnt + 7'd1;
                quarter_cnt         <= quarter_wrap ? 8'd0
                                                    : quarter_cnt + 8'd1;
                ms_edge             <= 1'b1;
                tenth_second_edge   <= tenth_wrap;
                quarter_second_edge <= quarter_wrap;
                second_edge         <= ms_wrap;
            end else if (enable) begin
                presc <= presc + PW'(1);
            end
        end
    end

`ifdef TIMEBASE_WB_EN
    logic [31:0] sec_cnt;
    logic        wb_req;
    logic        ctrl_wr;
    logic [31:0] rd_mux;
    logic        unused_bits;

    // Requests are only taken while ack is low, so a held strobe
    // produces ack every other cycle.
    assign wb_req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign ctrl_wr = wb_req & wb_we_i & (wb_adr_i[3:2] == 2'd0);
    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:2]};

    always_comb begin
        rd_mux = '0;
        case (wb_adr_i[3:2])
            2'd0:    rd_mux = {31'd0, enable};
            2'd1:    rd_mux = {22'd0, ms_cnt};
            2'd2:    rd_mux = sec_cnt;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            enable   <= 1'b1;
            clear    <= 1'b0;
        end else begin
            wb_ack_o <= wb_req;
            wb_dat_o <= (wb_req & ~wb_we_i) ? rd_mux : '0;
            clear    <= ctrl_wr & wb_dat_i[1];
            if (ctrl_wr) begin
                enable <= wb_dat_i[0];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sec_cnt <= '0;
        end else if (clear) begin
            sec_cnt <= '0;
        end else if (count_ms & ms_wrap) begin
            sec_cnt <= sec_cnt + 32'd1;
        end
    end
`else
    assign enable = 1'b1;
    assign clear  = 1'b0;
`endif

endmodule

// File: tb/tb_timebase_gen.sv
// tb_timebase_gen: randomized scoreboard bench for timebase_gen.
// Reference model counts enabled cycles and derives all outputs from it.
module tb_timebase_gen;

    localparam int C = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  adr = '0;
    logic [31:0] dat_i = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        ms_edge;
    logic        tenth_second_edge;
    logic        quarter_second_edge;
    logic        second_edge;
`ifdef TIMEBASE_WB_EN
    logic [31:0] dat_o;
    logic        ack;
`endif

    always #5 clk = ~clk;

    timebase_gen #(.CLKS_PER_MS(C)) dut (
        .wb_clk_i            (clk),
        .wb_rst_i            (rst),
`ifdef TIMEBASE_WB_EN
        .wb_adr_i            (adr),
        .wb_dat_i            (dat_i),
        .wb_dat_o            (dat_o),
        .wb_we_i             (we),
        .wb_cyc_i            (cyc),
        .wb_stb_i            (stb),
        .wb_ack_o            (ack),
`endif
        .ms_edge             (ms_edge),
        .tenth_second_edge   (tenth_second_edge),
        .quarter_second_edge (quarter_second_edge),
        .second_edge         (second_edge)
    );

    typedef struct {
        logic [3:0]  stb;
        logic        ack;
        logic [31:0] dat;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    // Model state: enabled-cycle count since reset/clear.
    longint n = 0;
    bit     m_en = 1'b1;
    bit     m_clr = 1'b0;
    bit     m_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h t=%0t",
                      name, act, exp, $time);
    endtask

    // Predict the effect of the next rising edge, then advance to negedge.
    task automatic cycle();
        exp_t        e;
        bit          acc;
        logic [31:0] rd;
        longint      ms;
        e.stb = '0;
        e.ack = 1'b0;
        e.dat = '0;
        if (rst) begin
            n = 0; m_en = 1'b1; m_clr = 1'b0; m_ack = 1'b0;
        end else begin
            ms  = n / C;
            acc = cyc && stb && !m_ack;
            case (adr[3:2])
                2'd0:    rd = {31'd0, m_en};
                2'd1:    rd = 32'(ms % 1000);
                2'd2:    rd = 32'(ms / 1000);
                default: rd = '0;
            endcase
            if (m_clr) n = 0;
            else if (m_en) begin
                n++;
                if (n % C == 0) begin
                    ms = n / C;
                    e.stb = {ms % 1000 == 0, ms % 250 == 0,
                             ms % 100 == 0, 1'b1};
                end
            end
            m_clr = acc && we && adr[3:2] == 2'd0 && dat_i[1];
            if (acc && we && adr[3:2] == 2'd0) m_en = dat_i[0];
            m_ack = acc;
            e.ack = acc;
            e.dat = (acc && !we) ? rd : '0;
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wb_op(input logic w, input logic [3:0] a,
                         input logic [31:0] d, input int hold);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
        repeat (hold) cycle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wait_phase(input int msv, input int ph);
        int k = 0;
        while (!((msv < 0 || (n / C) % 1000 == msv) && n % C == ph)
               && k < 20000) begin
            cycle();
            k++;
        end
        if (k >= 20000) begin
            total++;
            $display("FAIL wait_phase timeout ms=%0d ph=%0d", msv, ph);
        end
    endtask

    task automatic rand_run(input int cycles, input bit allow_rst);
        int r;
        for (int i = 0; i < cycles; i++) begin
            r = int'($urandom_range(0, 999));
            if (allow_rst && r == 0) begin
                rst = 1'b1;
                repeat (1 + $urandom_range(0, 2)) cycle();
                rst = 1'b0;
            end
`ifdef TIMEBASE_WB_EN
            else if (r < 40)
                wb_op(1'b0, 4'($urandom_range(0, 15)), 32'd0, 1);
            else if (allow_rst && r < 44)
                wb_op(1'b1, 4'd0, 32'($urandom_range(0, 3)), 1);
            else if (r < 48)
                wb_op(1'b1, 4'($urandom_range(4, 15)), $urandom, 1);
`endif
            else cycle();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("strobes", {28'd0, second_edge, quarter_second_edge,
                                tenth_second_edge, ms_edge}, {28'd0, e.stb});
`ifdef TIMEBASE_WB_EN
                chk("ack", {31'd0, ack}, {31'd0, e.ack});
                if (e.ack) chk("rdata", dat_o, e.dat);
`endif
            end
        end
    end

    initial begin : driver
        repeat (3) cycle();
        rst = 1'b0;
        repeat (4564) cycle();
        rst = 1'b1;
        #1;
        chk("rst_strobes", {28'd0, second_edge, quarter_second_edge,
                            tenth_second_edge, ms_edge}, 32'd0);
`ifdef TIMEBASE_WB_EN
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
`endif
        repeat (3) cycle();
        rst = 1'b0;
        rand_run(30005, 1'b0);
`ifdef TIMEBASE_WB_EN
        wb_op(1'b0, 4'h8, 32'd0, 1);
        wb_op(1'b0, 4'h4, 32'd0, 1);
        wait_phase(37, 2);
        wb_op(1'b1, 4'h0, 32'd0, 1);
        repeat (500) cycle();
        wb_op(1'b0, 4'h4, 32'd0, 1);
        wb_op(1'b0, 4'h0, 32'd0, 1);
        wb_op(1'b1, 4'h0, 32'd1, 1);
        repeat (12) cycle();
        wb_op(1'b0, 4'h4, 32'd0, 1);
        wait_phase(-1, 8);
        wb_op(1'b1, 4'h0, 32'd3, 1);
        repeat (3) cycle();
        wb_op(1'b0, 4'h4, 32'd0, 1);
        wb_op(1'b0, 4'h8, 32'd0, 1);
        wb_op(1'b0, 4'hC, 32'd0, 1);
        wb_op(1'b0, 4'h4, 32'd0, 4);
        wb_op(1'b1, 4'hC, 32'hFFFF_FFFF, 1);
`endif
        rand_run(6000, 1'b1);
`ifdef TIMEBASE_WB_EN
        wb_op(1'b1, 4'h0, 32'd1, 1);
        rand_run(1200, 1'b0);
`endif
        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/timebase_gen.md
# timebase_gen

Free-running timebase that produces the single-cycle strobes `ms_edge`, `tenth_second_edge`, `quarter_second_edge` and `second_edge` from the Wishbone system clock. It sits inside the SYSCON block, next to the clock/reset generator. Its strobes drive all millisecond-scale timing in the platform. An optional Wishbone slave port exposes the millisecond and seconds counters plus an enable/clear control.

## Interface
- `CLKS_PER_MS`, default 100000: `wb_clk_i` cycles per millisecond (100 MHz). Must be ≥ 2.
- `wb_clk_i`  in  1  system clock.
- `wb_rst_i`  in  1  reset, asynchronous assert, active-high.
- `ms_edge`  out  1  one-cycle pulse every 1 ms.
- `tenth_second_edge`  out  1  one-cycle pulse every 100 ms.
- `quarter_second_edge`  out  1  one-cycle pulse every 250 ms.
- `second_edge`  out  1  one-cycle pulse every 1000 ms.
- `wb_adr_i`  in  4  byte address; bits [3:2] decoded. Present only with `TIMEBASE_WB_EN`.
- `wb_dat_i`  in  32  write data. Present only with `TIMEBASE_WB_EN`.
- `wb_dat_o`  out  32  read data. Present only with `TIMEBASE_WB_EN`.
- `wb_we_i`, `wb_cyc_i`, `wb_stb_i`  in  1  Wishbone classic controls. Present only with `TIMEBASE_WB_EN`.
- `wb_ack_o`  out  1  Wishbone acknowledge. Present only with `TIMEBASE_WB_EN`.

## Operation
- Counter `presc`: width `$clog2(CLKS_PER_MS)`; counts 0..`CLKS_PER_MS`-1, then wraps.
- Counter `ms_cnt`: 10 bits; counts 0..999.
- Counter `sec_cnt`: 32 bits; increments on every second and wraps at 2^32-1 → 0.
- When `presc` == `CLKS_PER_MS`-1 and counting is enabled:
  - `presc` → 0 and `ms_edge` is registered high for one cycle.
  - `ms_cnt` increments, wrapping 999 → 0.
- On the same cycle as `ms_edge`, the following strobes are also high when the new `ms_cnt` value matches:
  - `tenth_second_edge`: new `ms_cnt` mod 100 == 0.
  - `quarter_second_edge`: new `ms_cnt` mod 250 == 0.
  - `second_edge`: new `ms_cnt` == 0.
- At each second boundary all four strobes are high together; `sec_cnt` increments on that cycle.
- Every strobe is a registered output, high for exactly one cycle.
- Reset forces all counters to 0, all strobes to 0, `wb_ack_o`=0, `wb_dat_o`=0, and enable=1. A reset mid-period discards the partial count.

## Timing
- First `ms_edge` occurs on the `CLKS_PER_MS`-th rising edge after `wb_rst_i` falls.
- Edge-to-edge periods are exact: `CLKS_PER_MS`×{1, 100, 250, 1000} cycles, with no drift.
- Wishbone (with macro only):
  - `wb_ack_o` is asserted one cycle after `wb_cyc_i & wb_stb_i`, is high for one cycle, and is deasserted the next cycle even if `wb_stb_i` stays high.
  - Reads are registered and return a value coherent with the cycle of the request.
- Register map:
  - 0x0 CTRL: bit0 enable (R/W, reset 1); bit1 clear (W, self-clearing, reads 0).
  - 0x4 MS: `ms_cnt` (RO).
  - 0x8 SEC: `sec_cnt` (RO).
  - 0xC: reads 0; writes ignored.
- Enable=0 freezes `presc`, `ms_cnt` and `sec_cnt`; no strobes fire. On re-enable, counting resumes from the frozen values.
- Clear zeros all three counters one cycle after the ack. It takes priority over a same-cycle terminal count: no strobe fires.

## Configuration
- `TIMEBASE_WB_EN` defined:
  - Wishbone ports, CTRL/MS/SEC registers and `sec_cnt` are present.
- `TIMEBASE_WB_EN` undefined:
  - No Wishbone ports and no `sec_cnt`.
  - Enable is permanently 1, so counting is free-running.
  - Strobe behaviour and timing are identical to the defined case.

## Test plan
- `CLKS_PER_MS`=10, release reset → `ms_edge` on cycle 10, then every 10 cycles. `tenth_second_edge` every 1000 cycles, `quarter_second_edge` every 2500, `second_edge` every 10000; each strobe is exactly 1 cycle wide.
- Run 3 s at `CLKS_PER_MS`=10 → at cycle 10000·k all four strobes are high together. SEC reads 3 and MS reads 0 after the third `second_edge`.
- Assert `wb_rst_i` at cycle 4567 for 3 cycles → all outputs go to 0 immediately. The next `ms_edge` comes 10 cycles after release.
- Write CTRL=0 at `ms_cnt`=37 and wait 500 cycles → no strobes and MS stays 37. Write CTRL=1 → MS reaches 38 after the remaining `presc` count.
- Write CTRL=3 while `presc` == 9 → no strobe that cycle; MS=0 and SEC=0 on subsequent reads.
- Read 0xC → `wb_dat_o`=0 with a single-cycle ack. Hold `wb_stb_i` high for 4 cycles → `wb_ack_o` pattern 0,1,0,1.
